// File: rtl/ahb_arbiter_param.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arbiter_param
// Purpose  : Parametrised AHB bus arbiter for NUM_MASTERS masters with a
//            selectable fixed-priority or round-robin policy. The grant is
//            held for the whole of a fixed-length burst (beats counted), for
//            an INCR burst while the owner keeps requesting, and for a locked
//            sequence while the owner keeps Hlock asserted. With no requests
//            the bus parks on DEFAULT_MASTER.
// Ports    : Hclk       in   bus clock
//            Hresetn    in   asynchronous active-low reset
//            Hreq       in   [NUM_MASTERS] bus request per master
//            Hlock      in   [NUM_MASTERS] locked-access request per master
//            Hready     in   transfer done / address phase accepted
//            Htrans     in   [2] owner's transfer type
//            Hburst     in   [3] owner's burst type
//            Hgrant     out  [NUM_MASTERS] one-hot grant, registered
//            Hmaster    out  [MW] address-phase owner index, registered
//            Hmastlock  out  current address phase is locked
// Revision : 1.0  initial release
// ============================================================================
module ahb_arbiter_param #(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic                   Hready,
    input  logic [1:0]             Htrans,
    input  logic [2:0]             Hburst,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MW-1:0]          Hmaster,
    output logic                   Hmastlock
);

    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;
    localparam logic [2:0] c_hburst_incr   = 3'b001;

    localparam logic [MW-1:0]          c_default_idx   = MW'(DEFAULT_MASTER);
    localparam logic [MW-1:0]          c_last_idx      = MW'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] c_grant_one     = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] c_default_grant = c_grant_one << DEFAULT_MASTER;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_INCR  = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_beat_cnt;
    logic [3:0]             w_beat_nxt;
    logic [MW-1:0]          r_rr_ptr;
    logic [MW-1:0]          w_rr_ptr_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [MW-1:0]          r_master;
    logic                   r_mastlock;

    logic [MW-1:0]          w_owner;
    logic                   w_owner_req;
    logic                   w_owner_lock;
    logic                   w_nonseq;
    logic                   w_fixed_burst;
    logic [3:0]             w_burst_last;
    logic                   w_rearb;
    logic                   w_win_valid;
    logic [MW-1:0]          w_win_idx;
    logic [NUM_MASTERS-1:0] w_arb_grant;

    // ------------------------------------------------------------------
    // Current owner is whoever holds the (always one-hot) grant.
    // ------------------------------------------------------------------
    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_owner = MW'(i);
            end
        end
    end

    assign w_owner_req   = Hreq[w_owner];
    assign w_owner_lock  = Hlock[w_owner];
    assign w_nonseq      = (Htrans == c_htrans_nonseq);
    assign w_fixed_burst = (Hburst[2:1] != 2'b00);

    // Beats remaining after the NONSEQ of a 4/8/16-beat burst.
    always_comb begin
        case (Hburst[2:1])
            2'b01:   w_burst_last = 4'd3;
            2'b10:   w_burst_last = 4'd7;
            default: w_burst_last = 4'd15;
        endcase
    end

    // ------------------------------------------------------------------
    // Winner selection. Only consumed on a re-arbitration edge.
    // ------------------------------------------------------------------
    generate
        if (ROUND_ROBIN != 0) begin : g_rr
            always_comb begin
                int idx;
                w_win_valid = 1'b0;
                w_win_idx   = c_default_idx;
                idx         = 0;
                // Search upward from the pointer, wrapping at the top index.
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    idx = int'(r_rr_ptr) + k;
                    if (idx >= NUM_MASTERS) begin
                        idx = idx - NUM_MASTERS;
                    end
                    if (!w_win_valid && Hreq[idx[MW-1:0]]) begin
                        w_win_valid = 1'b1;
                        w_win_idx   = idx[MW-1:0];
                    end
                end
            end

            // Pointer moves past a winner that really requested; a park
            // leaves it alone.
            always_comb begin
                w_rr_ptr_nxt = r_rr_ptr;
                if (w_win_valid) begin
                    w_rr_ptr_nxt = (w_win_idx == c_last_idx) ? '0 : w_win_idx + 1'b1;
                end
            end
        end else begin : g_fp
            always_comb begin
                w_win_valid = 1'b0;
                w_win_idx   = c_default_idx;
                // Scan downward so the lowest requesting index is kept.
                for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                    if (Hreq[i]) begin
                        w_win_valid = 1'b1;
                        w_win_idx   = MW'(i);
                    end
                end
            end

            always_comb begin
                w_rr_ptr_nxt = r_rr_ptr;
            end
        end
    endgenerate

    assign w_arb_grant = w_win_valid ? (c_grant_one << w_win_idx) : c_default_grant;

    // ------------------------------------------------------------------
    // Grant-holding state machine: next state and re-arbitration request.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        w_rearb     = 1'b0;
        case (r_state)
            ST_ARB: begin
                // A locked NONSEQ takes the lock path even if it is a burst.
                if (w_nonseq && w_owner_lock) begin
                    w_state_nxt = ST_LOCK;
                end else if (w_nonseq && w_fixed_burst) begin
                    w_state_nxt = ST_BURST;
                    w_beat_nxt  = w_burst_last;
                end else if (w_nonseq && (Hburst == c_hburst_incr)) begin
                    w_state_nxt = ST_INCR;
                end else begin
                    w_rearb = 1'b1;
                end
            end
            ST_BURST: begin
                if (Htrans == c_htrans_seq) begin
                    if (r_beat_cnt <= 4'd1) begin
                        // Last beat accepted: hand the bus on this edge.
                        w_rearb     = 1'b1;
                        w_beat_nxt  = 4'd0;
                        w_state_nxt = ST_ARB;
                    end else begin
                        w_beat_nxt = r_beat_cnt - 4'd1;
                    end
                end else if (Htrans != c_htrans_busy) begin
                    // IDLE or NONSEQ mid-burst ends the burst early.
                    w_rearb     = 1'b1;
                    w_beat_nxt  = 4'd0;
                    w_state_nxt = ST_ARB;
                end
            end
            ST_INCR: begin
                if (!w_owner_req) begin
                    w_rearb     = 1'b1;
                    w_state_nxt = ST_ARB;
                end
            end
            ST_LOCK: begin
                if (!w_owner_lock) begin
                    w_rearb     = 1'b1;
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                w_rearb     = 1'b1;
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register. Everything advances only on accepted phases.
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state    <= ST_ARB;
            r_beat_cnt <= 4'd0;
            r_rr_ptr   <= '0;
            r_grant    <= c_default_grant;
            r_master   <= c_default_idx;
            r_mastlock <= 1'b0;
        end else if (Hready) begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            if (w_rearb) begin
                r_grant  <= w_arb_grant;
                r_rr_ptr <= w_rr_ptr_nxt;
            end
            // Data-phase view trails the grant by one accepted phase.
            r_master   <= w_owner;
            r_mastlock <= w_owner_lock;
        end
    end

    assign Hgrant    = r_grant;
    assign Hmaster   = r_master;
    assign Hmastlock = r_mastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_arbiter_param
// Purpose  : Self-checking bench for ahb_arbiter_param. A round-robin and a
//            fixed-priority instance share the same stimulus; both are
//            compared every cycle against a transaction-level model, plus a
//            vector table and directed multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_arbiter_param;

    localparam int N = 4;

    logic         Hclk = 1'b0;
    logic         Hresetn;
    logic [N-1:0] Hreq;
    logic [N-1:0] Hlock;
    logic         Hready;
    logic [1:0]   Htrans;
    logic [2:0]   Hburst;
    logic [N-1:0] grant_rr, grant_fp;
    logic [1:0]   master_rr, master_fp;
    logic         mlock_rr, mlock_fp;

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = fixed priority, 1 = round robin.
    // mode: 0 free, 1 counted burst, 2 INCR, 3 locked
    int m_owner[2];
    int m_mode[2];
    int m_rem[2];
    int m_ptr[2];
    int m_master[2];
    bit m_mlock[2];

    ahb_arbiter_param #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)) u_rr (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
        .Htrans(Htrans), .Hburst(Hburst), .Hgrant(grant_rr), .Hmaster(master_rr),
        .Hmastlock(mlock_rr));

    ahb_arbiter_param #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .ROUND_ROBIN(0)) u_fp (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hreq(Hreq), .Hlock(Hlock), .Hready(Hready),
        .Htrans(Htrans), .Hburst(Hburst), .Hgrant(grant_fp), .Hmaster(master_fp),
        .Hmastlock(mlock_fp));

    always #5 Hclk = ~Hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int pol, input logic [N-1:0] req, input int ptr);
        if (req == '0) return 0;
        if (pol == 0) begin
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_owner[p] = 0; m_mode[p] = 0; m_rem[p] = 0;
            m_ptr[p] = 0; m_master[p] = 0; m_mlock[p] = 1'b0;
        end
    endtask

    // One accepted address phase.
    task automatic model_edge(input logic [N-1:0] req, input logic [N-1:0] lock,
                              input logic [1:0] trans, input logic [2:0] burst);
        int  prev;
        bit  rearb;
        int  b;
        for (int p = 0; p < 2; p++) begin
            prev  = m_owner[p];
            rearb = 1'b0;
            b     = int'(burst[2:1]);
            case (m_mode[p])
                0: begin
                    if (trans == 2'b10 && lock[prev]) m_mode[p] = 3;
                    else if (trans == 2'b10 && b != 0) begin
                        m_mode[p] = 1;
                        m_rem[p]  = (2 << b) - 1;
                    end else if (trans == 2'b10 && burst == 3'b001) m_mode[p] = 2;
                    else rearb = 1'b1;
                end
                1: begin
                    if (trans == 2'b11) begin
                        m_rem[p] = m_rem[p] - 1;
                        if (m_rem[p] == 0) rearb = 1'b1;
                    end else if (trans != 2'b01) rearb = 1'b1;
                    if (rearb) m_rem[p] = 0;
                end
                2: if (!req[prev]) rearb = 1'b1;
                default: if (!lock[prev]) rearb = 1'b1;
            endcase
            if (rearb) begin
                m_mode[p]  = 0;
                m_owner[p] = pick(p, req, m_ptr[p]);
                if (p == 1 && req != '0) m_ptr[p] = (m_owner[p] + 1) % N;
            end
            m_master[p] = prev;
            m_mlock[p]  = lock[prev];
        end
    endtask

    task automatic compare_all();
        chk("grant_fp",   grant_fp,  32'(1) << m_owner[0]);
        chk("grant_rr",   grant_rr,  32'(1) << m_owner[1]);
        chk("master_fp",  master_fp, m_master[0]);
        chk("master_rr",  master_rr, m_master[1]);
        chk("mlock_fp",   mlock_fp,  m_mlock[0]);
        chk("mlock_rr",   mlock_rr,  m_mlock[1]);
        chk("onehot_fp",  $onehot(grant_fp), 1);
        chk("onehot_rr",  $onehot(grant_rr), 1);
    endtask

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] lock,
                        input logic [1:0] trans, input logic [2:0] burst, input logic rdy);
        Hreq = req; Hlock = lock; Htrans = trans; Hburst = burst; Hready = rdy;
        @(posedge Hclk);
        if (rdy) model_edge(req, lock, trans, burst);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must react at once.
    task automatic do_reset();
        Hresetn = 1'b0;
        Hreq = '0; Hlock = '0; Htrans = 2'b00; Hburst = 3'b000; Hready = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(posedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_fp;
        int           exp_rr_master;
    } vec_t;

    vec_t vecs[12];

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    initial begin
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001, 0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001, 1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001, 2};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 3};
        vecs[5]  = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 0};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 1};
        vecs[7]  = '{4'b1011, 1'b1, 4'b0001, 4'b0001, 3};
        vecs[8]  = '{4'b0100, 1'b0, 4'b0001, 4'b0001, 3};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 0};
        vecs[10] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 0};
        vecs[11] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 2};

        Hresetn = 1'b1;
        Hreq = '0; Hlock = '0; Htrans = IDLE; Hburst = 3'b000; Hready = 1'b1;
        #1;
        do_reset();
        chk("reset_grant_rr",  grant_rr,  4'b0001);
        chk("reset_master_rr", master_rr, 0);
        chk("reset_mlock_rr",  mlock_rr,  0);

        // Rotation, fixed priority, stall and park via the vector table.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].req, 4'b0000, IDLE, 3'b000, vecs[i].rdy);
            chk($sformatf("tbl%0d_grant_rr", i), grant_rr, vecs[i].exp_rr);
            chk($sformatf("tbl%0d_grant_fp", i), grant_fp, vecs[i].exp_fp);
            chk($sformatf("tbl%0d_master_rr", i), master_rr, vecs[i].exp_rr_master);
        end

        // M0 INCR4 with one BUSY while M2 waits.
        do_reset();
        step(4'b0101, 4'b0000, IDLE, 3'b000, 1'b1);
        step(4'b0101, 4'b0000, NSEQ, 3'b011, 1'b1);
        step(4'b0101, 4'b0000, BUSY, 3'b011, 1'b1);
        step(4'b0101, 4'b0000, SEQ,  3'b011, 1'b1);
        step(4'b0101, 4'b0000, SEQ,  3'b011, 1'b1);
        chk("incr4_hold_rr", grant_rr, 4'b0001);
        step(4'b0101, 4'b0000, SEQ,  3'b011, 1'b1);
        chk("incr4_end_rr", grant_rr, 4'b0100);
        chk("incr4_end_fp", grant_fp, 4'b0001);
        step(4'b0100, 4'b0000, IDLE, 3'b000, 1'b1);
        chk("incr4_master_rr", master_rr, 2);

        // M1 INCR of 6 beats with a 2-cycle stall, then release and park.
        do_reset();
        step(4'b0010, 4'b0000, IDLE, 3'b000, 1'b1);
        step(4'b0011, 4'b0000, NSEQ, 3'b001, 1'b1);
        step(4'b0011, 4'b0000, SEQ,  3'b001, 1'b1);
        step(4'b0011, 4'b0000, SEQ,  3'b001, 1'b1);
        step(4'b0011, 4'b0000, SEQ,  3'b001, 1'b0);
        step(4'b0011, 4'b0000, SEQ,  3'b001, 1'b0);
        chk("incr_stall_rr", grant_rr, 4'b0010);
        chk("incr_stall_fp", grant_fp, 4'b0010);
        for (int i = 0; i < 3; i++) step(4'b0011, 4'b0000, SEQ, 3'b001, 1'b1);
        chk("incr_held_fp", grant_fp, 4'b0010);
        step(4'b0001, 4'b0000, IDLE, 3'b000, 1'b1);
        chk("incr_release_rr", grant_rr, 4'b0001);
        step(4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
        chk("park_grant_rr", grant_rr, 4'b0001);
        chk("park_mlock_rr", mlock_rr, 0);

        // M3 locked sequence, then M3 IDLE mid-INCR8.
        do_reset();
        step(4'b1000, 4'b0000, IDLE, 3'b000, 1'b1);
        step(4'b1001, 4'b1000, NSEQ, 3'b000, 1'b1);
        step(4'b1001, 4'b1000, IDLE, 3'b000, 1'b1);
        step(4'b1001, 4'b1000, SEQ,  3'b000, 1'b1);
        chk("lock_grant_rr", grant_rr, 4'b1000);
        chk("lock_grant_fp", grant_fp, 4'b1000);
        chk("lock_mlock_rr", mlock_rr, 1);
        step(4'b1001, 4'b0000, IDLE, 3'b000, 1'b1);
        chk("unlock_grant_rr", grant_rr, 4'b0001);
        chk("unlock_mlock_rr", mlock_rr, 0);
        step(4'b1000, 4'b0000, IDLE, 3'b000, 1'b1);
        step(4'b1001, 4'b0000, NSEQ, 3'b101, 1'b1);
        step(4'b1001, 4'b0000, SEQ,  3'b101, 1'b1);
        step(4'b1001, 4'b0000, SEQ,  3'b101, 1'b1);
        chk("incr8_hold_rr", grant_rr, 4'b1000);
        step(4'b1001, 4'b0000, IDLE, 3'b101, 1'b1);
        chk("incr8_early_rr", grant_rr, 4'b0001);
        chk("incr8_early_fp", grant_fp, 4'b0001);

        // Reset pulsed in the middle of an INCR16 owned by M2.
        do_reset();
        step(4'b0100, 4'b0000, IDLE, 3'b000, 1'b1);
        step(4'b0100, 4'b0000, NSEQ, 3'b111, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000, SEQ, 3'b111, 1'b1);
        chk("incr16_master_rr", master_rr, 2);
        do_reset();
        chk("rst_mid_grant_rr",  grant_rr,  4'b0001);
        chk("rst_mid_master_rr", master_rr, 0);
        chk("rst_mid_mlock_rr",  mlock_rr,  0);
        step(4'b0010, 4'b0000, SEQ, 3'b111, 1'b1);
        chk("rst_burst_lost_rr", grant_rr, 4'b0010);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rq, lk;
            if ($urandom_range(0, 499) == 0) do_reset();
            rq = N'($urandom);
            for (int j = 0; j < N; j++) lk[j] = ($urandom_range(0, 4) == 0);
            step(rq, lk, 2'($urandom), 3'($urandom), $urandom_range(0, 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
